// File: rtl/bs_arb_pkg.sv
// Shared types and helpers for the bus arbiter/router.
package bs_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      ROUTE   = 2'd2,
      DELIVER = 2'd3
   } state_t;

   localparam int DEF_ID_W = 8;

   // Header IDs are zero-extended to 32 bits so one helper serves every ID_W.
   function automatic logic is_broadcast(input logic [31:0] id, input logic [31:0] bc_id);
      return (id == bc_id);
   endfunction

endpackage

// File: rtl/bs_rr_arbiter_bp_rr_arbiter.sv
// Combinational requester selection: round-robin from a pointer, or fixed
// priority where the lowest index wins.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic             i_mode,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_valid
);

   // scan candidates in priority order and keep the first requester found
   always_comb begin : p_pick
      logic             w_found;
      logic [IDX_W-1:0] w_sel;
      w_found     = 1'b0;
      w_sel       = '0;
      o_gnt_idx   = '0;
      o_gnt_valid = |i_req;
      for (int k = 0; k < N; k++) begin
         w_sel = i_mode ? IDX_W'(k) : IDX_W'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_sel]) begin
            w_found   = 1'b1;
            o_gnt_idx = w_sel;
         end
      end
   end

endmodule

// File: rtl/bs_rr_arbiter_bp.sv
// Single-bus arbiter/router. It pops one packet from a source FIFO, decodes
// the header ID, and then pushes to one destination (unicast), pushes to all
// others (broadcast), or drops the packet. Delivery waits on destination
// full; undeliverable packets go to a saturating drop counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no packet in flight; arbitrate among pending sources
// POP     | pop strobe high for the winner; capture head data and source
// ROUTE   | decode header; drop, or push straight away if targets are free
// DELIVER | hold the packet until every target is not full, then push once
//
// Full is sampled at the clock edge that launches push. As a result, push is
// high in the cycle after the targets were seen free.
module bs_rr_arbiter_bp
   import bs_arb_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter int              ID_W      = DEF_ID_W,
   parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}},
   parameter int              CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   d_pop,
   output logic [drvrs-1:0]           pop,
   input  logic [drvrs-1:0]           full,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         d_push,
   input  logic                       mode,
   output logic                       busy,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int               IDX_W = $clog2(drvrs);
   localparam logic [drvrs-1:0] ONE   = drvrs'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_win;
   logic [IDX_W-1:0]   r_src_q;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic               w_gnt_valid;
   logic [pckg_sz-1:0] r_pkt_q;
   logic [pckg_sz-1:0] r_d_push;
   logic [drvrs-1:0]   r_tgt;
   logic [drvrs-1:0]   r_pop;
   logic [drvrs-1:0]   r_push;
   logic [drvrs-1:0]   w_pop_nxt;
   logic [drvrs-1:0]   w_push_nxt;
   logic [drvrs-1:0]   w_tgt_dec;
   logic [ID_W-1:0]    w_id;
   logic               w_drop;
   logic [CNT_W-1:0]   r_drop_cnt;
   logic               r_busy;

   rr_arbiter #(.N(drvrs), .IDX_W(IDX_W)) u_rr (
      .i_req       (pndng),
      .i_ptr       (r_ptr),
      .i_mode      (mode),
      .o_gnt_idx   (w_gnt_idx),
      .o_gnt_valid (w_gnt_valid)
   );

   assign w_id = r_pkt_q[pckg_sz-1 -: ID_W];

   // header decode: broadcast excludes the source; unicast must be in range and not self
   always_comb begin
      w_tgt_dec = '0;
      if (is_broadcast(32'(w_id), 32'(broadcast))) begin
         w_tgt_dec = ~(ONE << r_src_q);
      end else if ((32'(w_id) < 32'(drvrs)) && (32'(w_id) != 32'(r_src_q))) begin
         w_tgt_dec = ONE << w_id;
      end
      w_drop = (w_tgt_dec == '0);
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_valid) w_state_nxt = POP;
         POP:     w_state_nxt = ROUTE;
         ROUTE:   w_state_nxt = w_drop ? IDLE : DELIVER;
         DELIVER: if (|r_push) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // next values of the strobe outputs
   always_comb begin
      w_pop_nxt  = '0;
      w_push_nxt = '0;
      case (r_state)
         IDLE:    if (w_gnt_valid) w_pop_nxt = ONE << w_gnt_idx;
         ROUTE:   if (!w_drop && ((w_tgt_dec & full) == '0)) w_push_nxt = w_tgt_dec;
         DELIVER: if ((r_push == '0) && ((r_tgt & full) == '0)) w_push_nxt = r_tgt;
         default: ;
      endcase
   end

   // registered outputs, packet/source/target capture, RR pointer and drop counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pop      <= '0;
         r_push     <= '0;
         r_d_push   <= '0;
         r_busy     <= 1'b0;
         r_drop_cnt <= '0;
         r_ptr      <= '0;
         r_win      <= '0;
         r_src_q    <= '0;
         r_pkt_q    <= '0;
         r_tgt      <= '0;
      end else begin
         r_pop  <= w_pop_nxt;
         r_push <= w_push_nxt;
         r_busy <= (w_state_nxt != IDLE);
         if (w_push_nxt != '0) r_d_push <= r_pkt_q;
         case (r_state)
            IDLE: if (w_gnt_valid) r_win <= w_gnt_idx;
            POP: begin
               r_pkt_q <= d_pop[int'(r_win)*pckg_sz +: pckg_sz];
               r_src_q <= r_win;
               r_ptr   <= (r_win == IDX_W'(drvrs-1)) ? '0 : r_win + 1'b1;
            end
            ROUTE: begin
               if (w_drop) begin
                  if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
               end else begin
                  r_tgt <= w_tgt_dec;
               end
            end
            default: ;
         endcase
      end
   end

   assign pop      = r_pop;
   assign push     = r_push;
   assign d_push   = r_d_push;
   assign busy     = r_busy;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bs_rr_arbiter_bp.sv
// Bench for bs_rr_arbiter_bp. Source FIFOs are modelled as queues, and each
// transaction is compared against a transaction-level reference model.
module tb_bs_rr_arbiter_bp;

   localparam int N  = 4;
   localparam int PW = 16;
   localparam int IW = 8;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    pndng = '0;
   logic [N*PW-1:0] d_pop = '0;
   logic [N-1:0]    full = '0;
   logic            mode = 1'b0;
   logic [N-1:0]    pop, push;
   logic [PW-1:0]   d_push;
   logic            busy;
   logic [CW-1:0]   drop_cnt;

   bs_rr_arbiter_bp #(.drvrs(N), .pckg_sz(PW), .ID_W(IW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .d_pop(d_pop), .pop(pop),
      .full(full), .push(push), .d_push(d_push), .mode(mode), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] q [N][$];
   logic [N-1:0] last_pop = '0;
   logic [N-1:0] bp_mask = '0;
   int           bp_cnt = 0;
   bit           rnd_full = 0;
   int           m_ptr = 0;
   int           m_drop = 0;

   logic [N-1:0]  s_pndng, s_full;
   logic          s_mode;
   logic [N-1:0]  obs_pop, obs_push;
   logic [PW-1:0] obs_dpush;
   logic          obs_busy;
   logic [CW-1:0] obs_drop;

   bit            x_to, x_bad, x_mode;
   int            x_w, x_npush, x_lat, x_hlen;
   logic [N-1:0]  x_pnd, x_popmask, x_mask;
   logic [PW-1:0] x_data, x_pkt;
   logic [N-1:0]  x_fh [256];

   task automatic drive_inputs;
      for (int i = 0; i < N; i++) begin
         pndng[i] = (q[i].size() != 0);
         d_pop[i*PW +: PW] = (q[i].size() != 0) ? q[i][0] : '0;
      end
      if (bp_cnt > 0) begin
         full = bp_mask;
         bp_cnt--;
      end else if (rnd_full) begin
         full = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      end else begin
         full = '0;
      end
   endtask

   // One clock: note inputs at the edge, apply FIFO dequeues, sample outputs, re-drive.
   task automatic tick;
      s_pndng = pndng;
      s_mode  = mode;
      s_full  = full;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (last_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
      last_pop  = pop;
      obs_pop   = pop;
      obs_push  = push;
      obs_dpush = d_push;
      obs_busy  = busy;
      obs_drop  = drop_cnt;
      drive_inputs();
   endtask

   task automatic do_reset;
      reset = 1'b1;
      for (int i = 0; i < N; i++) q[i].delete();
      last_pop = '0; bp_cnt = 0; rnd_full = 0; m_ptr = 0; m_drop = 0;
      pndng = '0; d_pop = '0; full = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Runs one transaction and records what happened; tests judge the record.
   task automatic run_xact;
      int n, k;
      x_to = 0; x_bad = 0; x_w = -1; x_npush = 0; x_mask = '0; x_data = '0;
      x_lat = -1; x_hlen = 0; x_pkt = '0;
      n = 0;
      do begin tick(); n++; end while (obs_pop == '0 && n < 60);
      if (obs_pop == '0) begin x_to = 1; return; end
      x_pnd = s_pndng; x_mode = s_mode; x_popmask = obs_pop;
      if (obs_push != '0 || !obs_busy) x_bad = 1;
      for (int i = N - 1; i >= 0; i--) if (obs_pop[i]) x_w = i;
      if (q[x_w].size() != 0) x_pkt = q[x_w][0];
      else x_bad = 1;
      x_fh[0] = s_full;
      k = 0;
      while (obs_busy && k < 200) begin
         tick();
         k++;
         x_fh[k] = s_full;
         if (obs_pop != '0) x_bad = 1;
         if (obs_push != '0) begin
            x_npush++; x_mask = obs_push; x_data = obs_dpush; x_lat = k;
         end
      end
      x_hlen = k;
      if (obs_busy) x_to = 1;
   endtask

   function automatic logic [N-1:0] exp_tgt(int src, logic [15:0] pkt);
      int id;
      id = int'(pkt[15:8]);
      if (id == 255) return 4'hF & ~(4'b0001 << src);
      if (id < N && id != src) return 4'b0001 << id;
      return '0;
   endfunction

   function automatic int model_pick(logic [N-1:0] pend, int ptr, bit md);
      for (int off = 0; off < N; off++) begin
         int idx;
         idx = md ? off : (ptr + off) % N;
         if (pend[idx]) return idx;
      end
      return -1;
   endfunction

   // Push becomes visible at the first observation k>=2 whose edge saw every target free.
   function automatic int exp_lat(logic [N-1:0] tgt);
      for (int k = 2; k <= x_hlen; k++) if ((tgt & x_fh[k]) == '0) return k;
      return -1;
   endfunction

   function automatic logic [15:0] rand_pkt();
      int r;
      logic [7:0] id;
      r = $urandom_range(0, 9);
      if (r < 6)      id = 8'($urandom_range(0, 3));
      else if (r < 8) id = 8'hFF;
      else            id = 8'($urandom_range(4, 254));
      return {id, 8'($urandom)};
   endfunction

   task automatic test_reset;
      #12;
      checks++; if (pop !== '0)    begin failures++; $display("FAIL reset_pop: got %b want 0", pop); end
      checks++; if (push !== '0)   begin failures++; $display("FAIL reset_push: got %b want 0", push); end
      checks++; if (d_push !== '0) begin failures++; $display("FAIL reset_d_push: got %h want 0", d_push); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      do_reset();
   endtask

   task automatic test_unicast;
      q[0].push_back(16'h0201);
      run_xact();
      checks++; if (x_to || x_bad) begin failures++; $display("FAIL unicast_proto: timeout=%0d bad=%0d want 0 0", x_to, x_bad); end
      checks++; if (x_popmask !== 4'b0001) begin failures++; $display("FAIL unicast_pop: got %b want 0001", x_popmask); end
      checks++; if (x_mask !== 4'b0100 || x_npush != 1) begin failures++; $display("FAIL unicast_push: got %b x%0d want 0100 x1", x_mask, x_npush); end
      checks++; if (x_data !== 16'h0201) begin failures++; $display("FAIL unicast_data: got %h want 0201", x_data); end
      checks++; if (x_lat != 2) begin failures++; $display("FAIL unicast_latency: got %0d want 2", x_lat); end
      checks++; if (obs_drop !== '0) begin failures++; $display("FAIL unicast_drop: got %0d want 0", obs_drop); end
   endtask

   task automatic test_arbitration;
      do_reset();
      for (int i = 0; i < N; i++) q[i].push_back({8'((i + 1) % N), 8'(i)});
      mode = 1'b0;
      for (int j = 0; j < N; j++) begin
         run_xact();
         checks++; if (x_to || x_w != j) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", j, x_w, j); end
      end
      mode = 1'b1;
      q[3].push_back(16'h0033);
      q[1].push_back(16'h0211);
      run_xact();
      checks++; if (x_to || x_w != 1) begin failures++; $display("FAIL fixed_first: got %0d want 1", x_w); end
      run_xact();
      checks++; if (x_to || x_w != 3) begin failures++; $display("FAIL fixed_second: got %0d want 3", x_w); end
      mode = 1'b0;
   endtask

   task automatic test_broadcast;
      q[1].push_back(16'hFFAB);
      run_xact();
      checks++; if (x_to || x_w != 1) begin failures++; $display("FAIL bcast_src: got %0d want 1", x_w); end
      checks++; if (x_mask !== 4'b1101 || x_npush != 1) begin failures++; $display("FAIL bcast_push: got %b x%0d want 1101 x1", x_mask, x_npush); end
      checks++; if (x_data !== 16'hFFAB) begin failures++; $display("FAIL bcast_data: got %h want FFAB", x_data); end
   endtask

   task automatic test_drops;
      do_reset();
      q[0].push_back(16'h07CC);
      run_xact();
      checks++; if (x_to || x_npush != 0) begin failures++; $display("FAIL drop_range_push: got %0d pushes want 0", x_npush); end
      checks++; if (obs_drop !== 3'd1) begin failures++; $display("FAIL drop_range_cnt: got %0d want 1", obs_drop); end
      q[1].push_back(16'h0155);
      run_xact();
      checks++; if (x_to || x_npush != 0) begin failures++; $display("FAIL drop_self_push: got %0d pushes want 0", x_npush); end
      checks++; if (obs_drop !== 3'd2) begin failures++; $display("FAIL drop_self_cnt: got %0d want 2", obs_drop); end
      checks++; if (x_hlen != 2) begin failures++; $display("FAIL drop_busy_len: busy fell after %0d want 2", x_hlen); end
   endtask

   task automatic test_backpressure;
      q[0].push_back(16'h0299);
      bp_mask = 4'b0100; bp_cnt = 6;
      run_xact();
      checks++; if (x_to || x_mask !== 4'b0100 || x_npush != 1) begin failures++; $display("FAIL bp_push: got %b x%0d want 0100 x1", x_mask, x_npush); end
      checks++; if (x_data !== 16'h0299) begin failures++; $display("FAIL bp_data: got %h want 0299", x_data); end
      checks++; if (x_lat <= 2 || x_lat != exp_lat(4'b0100)) begin failures++; $display("FAIL bp_latency: got %0d want %0d", x_lat, exp_lat(4'b0100)); end
      q[1].push_back(16'hFFAB);
      bp_mask = 4'b1000; bp_cnt = 6;
      run_xact();
      checks++; if (x_to || x_mask !== 4'b1101 || x_npush != 1) begin failures++; $display("FAIL bp_bcast_push: got %b x%0d want 1101 x1", x_mask, x_npush); end
      checks++; if (x_lat <= 2 || x_lat != exp_lat(4'b1101)) begin failures++; $display("FAIL bp_bcast_latency: got %0d want %0d", x_lat, exp_lat(4'b1101)); end
   endtask

   task automatic test_reset_mid;
      int n;
      q[0].push_back(16'h0299);
      bp_mask = 4'b0100; bp_cnt = 50;
      n = 0;
      do begin tick(); n++; end while (obs_pop == '0 && n < 60);
      repeat (4) tick();
      checks++; if (obs_busy !== 1'b1 || obs_drop !== 3'd2) begin failures++; $display("FAIL rmid_pre: busy=%b drop=%0d want 1 2", obs_busy, obs_drop); end
      #2 reset = 1'b1;
      #1;
      checks++; if (push !== '0 || pop !== '0) begin failures++; $display("FAIL rmid_strobes: push=%b pop=%b want 0 0", push, pop); end
      checks++; if (busy !== 1'b0 || drop_cnt !== '0) begin failures++; $display("FAIL rmid_state: busy=%b drop=%0d want 0 0", busy, drop_cnt); end
      do_reset();
      q[0].push_back(16'h0102);
      q[3].push_back(16'h0012);
      mode = 1'b0;
      run_xact();
      checks++; if (x_to || x_w != 0 || x_mask !== 4'b0010) begin failures++; $display("FAIL rmid_first: src=%0d push=%b want 0 0010", x_w, x_mask); end
      run_xact();
      checks++; if (x_to || x_w != 3 || x_mask !== 4'b0001) begin failures++; $display("FAIL rmid_second: src=%0d push=%b want 3 0001", x_w, x_mask); end
   endtask

   task automatic test_random;
      int ew, el;
      logic [N-1:0] et;
      do_reset();
      rnd_full = 1;
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1 && q[i].size() < 3) q[i].push_back(rand_pkt());
         if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0)
            q[$urandom_range(0, N - 1)].push_back(rand_pkt());
         mode = 1'($urandom_range(0, 1));
         run_xact();
         ew = model_pick(x_pnd, m_ptr, x_mode);
         checks++; if (x_to || x_bad) begin failures++; $display("FAIL rnd_proto[%0d]: timeout=%0d bad=%0d want 0 0", t, x_to, x_bad); end
         checks++; if (x_w != ew || x_popmask !== (4'b0001 << ew)) begin failures++; $display("FAIL rnd_winner[%0d]: got %b want idx %0d", t, x_popmask, ew); end
         if (x_w >= 0) m_ptr = (x_w + 1) % N;
         et = exp_tgt(x_w, x_pkt);
         if (et == '0) m_drop = (m_drop == 7) ? 7 : m_drop + 1;
         el = (et == '0) ? -1 : exp_lat(et);
         checks++; if (x_npush != ((et == '0) ? 0 : 1) || x_mask !== et) begin failures++; $display("FAIL rnd_push[%0d]: got %b x%0d want %b", t, x_mask, x_npush, et); end
         checks++; if (et != '0 && (x_data !== x_pkt || x_lat != el)) begin failures++; $display("FAIL rnd_data[%0d]: got %h lat %0d want %h lat %0d", t, x_data, x_lat, x_pkt, el); end
         checks++; if (obs_drop !== CW'(m_drop)) begin failures++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", t, obs_drop, m_drop); end
      end
      rnd_full = 0;
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_arbitration();
      test_broadcast();
      test_drops();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bs_rr_arbiter_bp.md
Name: bs_rr_arbiter_bp

Overview:
Parametrised single-bus arbiter and router connecting `drvrs` devices. Each device has a show-ahead source FIFO (pending/pop/data) and a destination FIFO (push/data/full). The block selects one pending source per transaction, using either round-robin or fixed priority. It routes the packet by the destination ID in the packet header, supporting unicast and broadcast. Unlike the previous bus generator, it honours destination backpressure, drops undeliverable packets, and counts the drops. It is the next-generation DUT for the driver/monitor bench.

Parameters:
- drvrs, 4: number of devices, 2..16.
- pckg_sz, 16: packet width in bits; must be greater than ID_W.
- ID_W, 8: header ID width; the ID is packet bits [pckg_sz-1 : pckg_sz-ID_W].
- broadcast, {ID_W{1'b1}}: ID that means "deliver to all devices except the source".
- CNT_W, 16: drop counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  drvrs  source FIFO i is non-empty.
- d_pop  in  drvrs*pckg_sz  head-of-FIFO data; slice i is [i*pckg_sz +: pckg_sz]; valid while pndng[i]=1.
- pop  out  drvrs  one-cycle dequeue strobe to source FIFO i.
- full  in  drvrs  destination FIFO i cannot accept data.
- push  out  drvrs  one-cycle enqueue strobe to destination FIFO i.
- d_push  out  pckg_sz  packet data shared by all destinations; valid when any push bit is 1.
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (asynchronous, active-high): pop=0, push=0, d_push=0, busy=0, drop_cnt=0, FSM to IDLE, RR pointer=0. A packet already popped when reset asserts is lost and is not counted as a drop.
- All outputs are registered.
- FSM states: IDLE, POP, ROUTE, DELIVER.
- IDLE: if |pndng, select winner w and go to POP; otherwise stay.
  - Round-robin: first i with pndng[i]=1, searching from rr_ptr upward and wrapping at drvrs.
  - Fixed priority: lowest i with pndng[i]=1.
- POP: pop[w]=1 for exactly this cycle. Latch d_pop slice w into pkt_q and w into src_q. rr_ptr <= (w+1) mod drvrs, updated in both modes. Go to ROUTE.
- ROUTE: decode id = pkt_q header.
  - id == broadcast: tgt = all ones with bit src_q cleared.
  - id < drvrs and id != src_q: tgt = one-hot(id).
  - Otherwise (out-of-range ID or self-address): drop. drop_cnt increments, saturating at all ones. Return to IDLE with no push.
  - For a valid target, go to DELIVER.
- DELIVER: wait while any (tgt & full) bit is set. In the first cycle with (tgt & full)==0, assert push=tgt and d_push=pkt_q for one cycle, then go to IDLE. All broadcast targets are pushed in the same cycle. No timeout.
- Latency: pndng seen at edge k → pop high in cycle k+1 → push high in cycle k+3 at the earliest. Minimum 4 cycles per packet; one packet in flight at a time.
- pndng changes after the winner is chosen are ignored until the next IDLE.
- A mode change during a transaction takes effect at the next IDLE.
- full changes are re-evaluated every cycle in DELIVER.
- pop and push are never high in the same cycle.
- d_push holds its last value when push=0.

Decomposition:
- Package bs_arb_pkg:
  - state_t enum {IDLE, POP, ROUTE, DELIVER}.
  - Default ID_W.
  - Function is_broadcast().
- Sub-module rr_arbiter #(N): inputs req[N], ptr, mode; outputs gnt_idx and gnt_valid. Purely combinational, so it can be verified standalone.
- Main module contains the FSM, the pkt_q/src_q/tgt registers and the drop counter.

Test Plan (drvrs=4, pckg_sz=16, ID_W=8):
1. Unicast: dev0 holds 16'h0201, pndng=4'b0001 → pop[0] one cycle, push=4'b0100 with d_push=16'h0201 two cycles later, drop_cnt=0.
2. Arbitration: mode=0 with pndng=4'b1111 held (each FIFO has 1 packet) → grant order 0,1,2,3. Then mode=1 with devs 3 and 1 pending → dev1 served before dev3.
3. Broadcast: dev1 sends 16'hFFAB → a single cycle with push=4'b1101 and d_push=16'hFFAB.
4. Drops: dev0 sends 16'h07CC → no push, drop_cnt=1. Then dev1 sends 16'h0155 (self-address) → drop_cnt=2, busy back to 0.
5. Backpressure: full[2]=1 for 5 cycles while delivering 16'h0299 → push stays 0 and busy=1. push[2] asserts in the first cycle after full[2] falls. A broadcast with full[3]=1 waits for all targets.
6. Reset mid-DELIVER: assert reset between clock edges → push, pop, busy and drop_cnt go to 0 immediately. After release, rr_ptr=0, so dev0 wins first under mode=0.
